// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue that feeds the single register-file write port,
// with two combinational bypass lookups over the pending writes.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        EnqValid,
  output logic        EnqReady,
  input  logic [4:0]  EnqRegister,
  input  logic [31:0] EnqData,
  input  logic        DrainStall,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Hit1,
  output logic        Hit2,
  output logic [31:0] BypassData1,
  output logic [31:0] BypassData2,
  output logic [CW-1:0] Count
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]    r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_reg_write;
  logic [4:0]    r_write_register;
  logic [31:0]   r_write_data;

  logic          w_push;
  logic          w_pop;

  // Ready depends only on occupancy, so there is no path from EnqValid.
  assign EnqReady = (r_count != CW'(DEPTH));
  assign w_pop    = (r_count != '0) && !DrainStall;
  // Writes to r0 are accepted but never stored: they have no architectural effect.
  assign w_push   = EnqValid && EnqReady && (EnqRegister != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; r_count alone decides which entries are valid.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_addr[r_tail] <= EnqRegister;
      r_data[r_tail] <= EnqData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_reg_write      <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
    end else begin
      r_reg_write <= w_pop;
      if (w_pop) begin
        r_write_register <= r_addr[r_head];
        r_write_data     <= r_data[r_head];
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    Hit1        = 1'b0;
    Hit2        = 1'b0;
    BypassData1 = '0;
    BypassData2 = '0;
    if (r_reg_write && (ReadRegister1 != 5'd0) && (r_write_register == ReadRegister1)) begin
      Hit1        = 1'b1;
      BypassData1 = r_write_data;
    end
    if (r_reg_write && (ReadRegister2 != 5'd0) && (r_write_register == ReadRegister2)) begin
      Hit2        = 1'b1;
      BypassData2 = r_write_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(r_count)) begin
        if ((ReadRegister1 != 5'd0) && (r_addr[r_head + PW'(i)] == ReadRegister1)) begin
          Hit1        = 1'b1;
          BypassData1 = r_data[r_head + PW'(i)];
        end
        if ((ReadRegister2 != 5'd0) && (r_addr[r_head + PW'(i)] == ReadRegister2)) begin
          Hit2        = 1'b1;
          BypassData2 = r_data[r_head + PW'(i)];
        end
      end
    end
  end

  assign RegWrite      = r_reg_write;
  assign WriteRegister = r_write_register;
  assign WriteData     = r_write_data;
  assign Count         = r_count;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        EnqValid = 1'b0;
  logic        EnqReady;
  logic [4:0]  EnqRegister = '0;
  logic [31:0] EnqData = '0;
  logic        DrainStall = 1'b0;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic        Hit1, Hit2;
  logic [31:0] BypassData1, BypassData2;
  logic [CW-1:0] Count;

  regfile_writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .EnqValid(EnqValid), .EnqReady(EnqReady),
    .EnqRegister(EnqRegister), .EnqData(EnqData),
    .DrainStall(DrainStall),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Hit1(Hit1), .Hit2(Hit2),
    .BypassData1(BypassData1), .BypassData2(BypassData2),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes plus the committed-write stage.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_rw = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_wd = '0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q.delete();
      m_rw = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else begin
      bit   ready;
      ent_t e;
      ready = (q.size() != DEPTH);
      if (q.size() > 0 && !DrainStall) begin
        e    = q.pop_front();
        m_rw = 1'b1;
        m_wr = e.a;
        m_wd = e.d;
      end else begin
        m_rw = 1'b0;
      end
      if (EnqValid && ready && EnqRegister != 5'd0) begin
        e.a = EnqRegister;
        e.d = EnqData;
        q.push_back(e);
      end
    end
  end

  function automatic logic [32:0] model_lookup(input logic [4:0] rr);
    if (rr == 5'd0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == rr) return {1'b1, q[i].d};
    if (m_rw && m_wr == rr) return {1'b1, m_wd};
    return '0;
  endfunction

  always @(negedge Clk) begin
    logic [32:0] e1, e2;
    e1 = model_lookup(ReadRegister1);
    e2 = model_lookup(ReadRegister2);
    check("m_RegWrite",      RegWrite,      m_rw);
    check("m_WriteRegister", WriteRegister, m_wr);
    check("m_WriteData",     WriteData,     m_wd);
    check("m_Count",         Count,         q.size());
    check("m_EnqReady",      EnqReady,      q.size() != DEPTH);
    check("m_Hit1",          Hit1,          e1[32]);
    check("m_BypassData1",   BypassData1,   e1[31:0]);
    check("m_Hit2",          Hit2,          e2[32]);
    check("m_BypassData2",   BypassData2,   e2[31:0]);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic enq(input logic [4:0] r, input logic [31:0] d);
    EnqValid    = 1'b1;
    EnqRegister = r;
    EnqData     = d;
  endtask

  task automatic idle(input int n);
    EnqValid   = 1'b0;
    DrainStall = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    // Reset then idle
    #3;
    check("rst_RegWrite", RegWrite, 0);
    check("rst_WriteRegister", WriteRegister, 0);
    check("rst_WriteData", WriteData, 0);
    check("rst_Count", Count, 0);
    check("rst_Hit1", Hit1, 0);
    check("rst_BypassData2", BypassData2, 0);
    #4 Reset_n = 1'b1;
    repeat (5) begin
      step();
      check("idle_RegWrite", RegWrite, 0);
      check("idle_Count", Count, 0);
      check("idle_EnqReady", EnqReady, 1);
    end

    // Single write
    ReadRegister1 = 5'd5;
    enq(5'd5, 32'hDEADBEEF);
    step();
    EnqValid = 1'b0;
    #1;
    check("single_Count", Count, 1);
    check("single_Hit1", Hit1, 1);
    check("single_Bypass1", BypassData1, 32'hDEADBEEF);
    check("single_RegWrite0", RegWrite, 0);
    step();
    check("single_RegWrite1", RegWrite, 1);
    check("single_WriteRegister", WriteRegister, 5);
    check("single_WriteData", WriteData, 32'hDEADBEEF);
    check("single_Count0", Count, 0);
    check("single_Hit1_out", Hit1, 1);
    step();
    check("single_RegWrite_end", RegWrite, 0);
    check("single_Hit1_end", Hit1, 0);

    // Fill to full, then drain in order
    DrainStall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      enq(5'(k), 32'(k * 'h11));
      step();
    end
    check("full_Count", Count, 4);
    check("full_EnqReady", EnqReady, 0);
    DrainStall = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 2) EnqValid = 1'b0;
      check("drain_RegWrite", RegWrite, 1);
      check("drain_WriteRegister", WriteRegister, k);
      check("drain_WriteData", WriteData, k * 'h11);
    end
    step();
    check("drain_RegWrite_end", RegWrite, 0);

    // Youngest-wins bypass
    DrainStall = 1'b1;
    enq(5'd7, 32'hAAAA0000);
    step();
    enq(5'd7, 32'hBBBB0000);
    step();
    EnqValid      = 1'b0;
    ReadRegister2 = 5'd7;
    #1;
    check("young_Count", Count, 2);
    check("young_Hit2", Hit2, 1);
    check("young_Bypass2", BypassData2, 32'hBBBB0000);
    DrainStall = 1'b0;
    step();
    check("young_first_WriteData", WriteData, 32'hAAAA0000);
    check("young_first_Bypass2", BypassData2, 32'hBBBB0000);
    step();
    check("young_last_RegWrite", RegWrite, 1);
    check("young_last_WriteData", WriteData, 32'hBBBB0000);
    step();
    check("young_RegWrite_end", RegWrite, 0);

    // Register zero
    enq(5'd0, 32'hFFFFFFFF);
    step();
    EnqValid      = 1'b0;
    ReadRegister1 = 5'd0;
    #1;
    check("r0_Count", Count, 0);
    check("r0_Hit1", Hit1, 0);
    check("r0_Bypass1", BypassData1, 0);
    step();
    check("r0_RegWrite", RegWrite, 0);

    // Reset mid-operation
    DrainStall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      enq(5'(10 + k), 32'(k + 1));
      step();
    end
    EnqValid   = 1'b0;
    DrainStall = 1'b0;
    step();
    check("midrst_RegWrite_pre", RegWrite, 1);
    check("midrst_Count_pre", Count, 3);
    #1 Reset_n = 1'b0;
    #1;
    check("midrst_RegWrite", RegWrite, 0);
    check("midrst_Count", Count, 0);
    check("midrst_WriteRegister", WriteRegister, 0);
    step();
    Reset_n = 1'b1;
    repeat (4) begin
      step();
      check("midrst_after_RegWrite", RegWrite, 0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      EnqValid      = ($urandom_range(0, 99) < 60);
      EnqRegister   = 5'($urandom_range(0, 7));
      EnqData       = $urandom;
      DrainStall    = ($urandom_range(0, 99) < 35);
      ReadRegister1 = 5'($urandom_range(0, 7));
      ReadRegister2 = 5'($urandom_range(0, 7));
      if (c == 1500) begin
        #1 Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
      end
      step();
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
